seg_dynamic: RTL
================

// Module: seg_dynamic
// PURPOSE
//  Consumes the data_gen outputs (data/point/sign/seg_en) and drives a 6-digit
//  common-anode 7-segment display by time-multiplexed scanning. Converts the
//  20-bit binary value to BCD with a sequential shift-add-3 engine, blanks
//  leading zeros, and places a minus sign and decimal points. Its sel/seg
//  outputs feed the downstream hc595_ctrl shift-register driver.
// PARAMETERS
//  CNT_MAX  16'd49_999  per-digit dwell minus 1, in sys_clk cycles (1 ms @ 50 MHz)
// PORTS
//  sys_clk    in   1   system clock, 50 MHz
//  sys_rst_n  in   1   reset; asynchronous assert, active low
//  data       in   20  unsigned binary value to display
//  point      in   6   decimal point enables; point[i] is the dp of digit i
//  sign       in   1   1 = value is negative; show minus
//  seg_en     in   1   1 = display on, 0 = all digits off
//  sel        out  6   one-hot digit select, active high; sel[0] = rightmost digit
//  seg        out  8   segments, active low; seg[7] = dp, seg[6:0] = g..a
// BEHAVIOUR
//  Reset: sel=6'b000000, seg=8'hFF, scan counter=0, digit index=0, FSM=IDLE,
//   display registers = value 0, point 0, sign 0.
//  Conversion FSM, free-running: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE (1 cyc): latch data, saturated to 999_999 if data > 999_999, plus point
//    and sign; clear 24-bit BCD accumulator.
//   SHIFT (20 cyc): each cycle add 3 to every BCD nibble >= 5, then shift
//    {bcd,bin} left by 1.
//   DONE (1 cyc): copy BCD, point and sign into display registers in one cycle,
//    so the displayed value/point/sign never mix two samples.
//   Conversion period is 22 cycles; input change to display registers <= 44 cycles.
//  Scan: counter 0..CNT_MAX. At CNT_MAX it wraps to 0 and the digit index
//   advances 0..5, wrapping 5 -> 0. Each digit is shown for CNT_MAX+1 cycles.
//  Digit content for index i, taken from the display registers:
//   - msd = highest nonzero BCD digit; hp = highest set point bit. Both are 0
//     if there is no such digit or bit.
//   - Digit i is shown when i <= max(msd, hp). Digit 0 is always shown.
//   - Minus (8'hBF) is placed at digit max(msd,hp)+1 when sign=1 and that
//     position is <= 5. Otherwise the minus is dropped.
//   - All other digits are blank (8'hFF).
//   - Decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
//   - point[i]=1 clears seg[7] on digit i, including blank and minus digits.
//  Outputs are registered and reflect the index and display registers one cycle
//   later.
//  seg_en=0: sel=0 and seg=FF on the next cycle. The scan counter and the
//   conversion FSM keep running.
//  Reset asserted mid-conversion or mid-scan: all state returns to reset values
//   at once (asynchronous).
// TESTING (CNT_MAX=9, 20 ns clock)
//  1 Reset held 30 ns, any inputs -> sel=000000, seg=FF throughout reset.
//  2 data=123456, point=0, sign=0, seg_en=1 -> after <=44 cyc, repeating
//    sel/seg 000001/82, 000010/92, 000100/99, 001000/B0, 010000/A4,
//    100000/F9, each held 10 cyc.
//  3 data=42, sign=1 -> digit0 99, digit1 A4, digit2 BF, digits3-5 FF.
//  4 data=5, point=000100 -> digit0 92, digit1 C0, digit2 40, digits3-5 FF.
//    data=0 with point=0 -> digit0 C0 only.
//  5 data=20'hFFFFF, sign=1 -> all six digits 90 (saturated), no minus anywhere.
//  6 seg_en 1->0 mid-dwell -> next cycle sel=0, seg=FF. Re-enable -> scan
//    resumes at the current index with no restart.
//    Reset pulse mid-SHIFT -> reset values, then a clean conversion.

Source files
------------

// File: rtl/seg_dynamic.sv
// Six-digit common-anode 7-segment scanner. A shift-add-3 engine converts the
// saturated 20-bit input to BCD; the scan stage blanks leading zeros and places minus/dp.
module seg_dynamic #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [19:0] DATA_MAX = 20'd999_999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [4:0]  shift_cnt;
  logic [19:0] bin_p0;
  logic [23:0] bcd_p0;
  logic [5:0]  point_p0;
  logic        sign_p0;
  logic [23:0] disp_bcd_p1;
  logic [5:0]  disp_point_p1;
  logic        disp_sign_p1;
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [2:0]  msd;
  logic [2:0]  hp;
  logic [2:0]  top;
  logic [7:0]  digit_seg;

  function automatic logic [19:0] sat_data(input logic [19:0] d);
    return (d > DATA_MAX) ? DATA_MAX : d;
  endfunction

  function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
    logic [23:0] r;
    for (int n = 0; n < 6; n++)
      r[4*n +: 4] = (b[4*n +: 4] >= 4'd5) ? b[4*n +: 4] + 4'd3 : b[4*n +: 4];
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Stage p0: conversion engine; p1: display registers updated atomically in DONE
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      shift_cnt     <= '0;
      bin_p0        <= '0;
      bcd_p0        <= '0;
      point_p0      <= '0;
      sign_p0       <= 1'b0;
      disp_bcd_p1   <= '0;
      disp_point_p1 <= '0;
      disp_sign_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bin_p0    <= sat_data(data);
          point_p0  <= point;
          sign_p0   <= sign;
          bcd_p0    <= '0;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {bcd_p0, bin_p0} <= {bcd_adjust(bcd_p0), bin_p0} << 1;
          shift_cnt        <= shift_cnt + 5'd1;
          if (shift_cnt == 5'd19) state <= DONE;
        end
        DONE: begin
          disp_bcd_p1   <= bcd_p0;
          disp_point_p1 <= point_p0;
          disp_sign_p1  <= sign_p0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // The visible span runs to the higher of the top nonzero digit and the top dp
  always_comb begin
    msd = '0;
    hp  = '0;
    for (int n = 0; n < 6; n++) begin
      if (disp_bcd_p1[4*n +: 4] != 4'd0) msd = 3'(n);
      if (disp_point_p1[n])              hp  = 3'(n);
    end
    top       = (msd > hp) ? msd : hp;
    digit_seg = 8'hFF;
    if (digit_idx <= top)
      digit_seg = decode(disp_bcd_p1[{digit_idx, 2'b00} +: 4]);
    else if (disp_sign_p1 && (digit_idx == top + 3'd1))
      digit_seg = 8'hBF;
    if (disp_point_p1[digit_idx]) digit_seg[7] = 1'b0;
  end

  // Stage p2: registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'b000001 << digit_idx;
      seg <= digit_seg;
    end else begin
      sel <= '0;
      seg <= 8'hFF;
    end
  end

endmodule
